hsi_core_driver: RTL and testbench

Host-side initiator for the HSI vector core. It accepts two per-pixel component streams, serialized one component per beat, and packs each pixel's components into full-width band vectors. It writes those vectors into the core's two input FIFOs, issues start, and waits for pixel_done or an error. It then pops the result from the core's output FIFO and re-serializes it as a component stream, repeating for a programmed pixel count.

---
 rtl/hsi_core_driver.sv | 217 +++++++++++++++++++++
 tb/tb_hsi_core_driver.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsi_core_driver.sv
// Host-side initiator for the HSI vector core: packs serialized input components into
// band vectors, runs one core operation per pixel and re-serializes the result.
module hsi_core_driver #(
    parameter int COMPONENT_WIDTH = 16,
    parameter int COMPONENTS_MAX  = 200,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      go,
    input  logic [3:0]                                cfg_op_code,
    input  logic [31:0]                               cfg_num_bands,
    input  logic [15:0]                               cfg_num_pixels,
    input  logic                                      s_valid,
    output logic                                      s_ready,
    input  logic [COMPONENT_WIDTH-1:0]                s_data,
    output logic                                      m_valid,
    input  logic                                      m_ready,
    output logic [COMPONENT_WIDTH-1:0]                m_data,
    output logic                                      m_last,
    output logic                                      core_in1_wr_en,
    output logic [COMPONENT_WIDTH*COMPONENTS_MAX-1:0] core_in1_data,
    input  logic                                      core_in1_full,
    output logic                                      core_in2_wr_en,
    output logic [COMPONENT_WIDTH*COMPONENTS_MAX-1:0] core_in2_data,
    input  logic                                      core_in2_full,
    output logic                                      core_out_rd_en,
    input  logic                                      core_out_empty,
    input  logic [COMPONENT_WIDTH*COMPONENTS_MAX-1:0] core_out_data,
    output logic [3:0]                                core_op_code,
    output logic [31:0]                               core_num_bands,
    output logic                                      core_start,
    input  logic                                      core_pixel_done,
    input  logic [3:0]                                core_error_code,
    output logic                                      busy,
    output logic                                      done,
    output logic [3:0]                                err_code
);

    localparam int VW = COMPONENT_WIDTH * COMPONENTS_MAX;
    localparam int BW = $clog2(COMPONENTS_MAX + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_CHECK = 4'd1;
    localparam logic [3:0] S_LOAD1 = 4'd2;
    localparam logic [3:0] S_LOAD2 = 4'd3;
    localparam logic [3:0] S_PUSH  = 4'd4;
    localparam logic [3:0] S_KICK  = 4'd5;
    localparam logic [3:0] S_WAIT  = 4'd6;
    localparam logic [3:0] S_POP   = 4'd7;
    localparam logic [3:0] S_CAPT  = 4'd8;
    localparam logic [3:0] S_EMIT  = 4'd9;
    localparam logic [3:0] S_FIN   = 4'd10;

    logic [3:0]    r_state;
    logic [3:0]    r_op;
    logic [31:0]   r_nb;
    logic [15:0]   r_pix;
    logic [BW-1:0] r_k;
    logic [1:0]    r_j;
    logic [TW-1:0] r_to;
    logic [3:0]    r_err;
    logic [VW-1:0] r_vec1;
    logic [VW-1:0] r_vec2;
    logic [VW-1:0] r_res;

    logic       w_bad_cfg;
    logic       w_k_last;
    logic       w_push_ok;
    logic [1:0] w_last_idx;

    assign w_bad_cfg = (r_nb == 32'd0) || (r_nb > 32'(COMPONENTS_MAX)) ||
                       !((r_op == 4'd1) || (r_op == 4'd2)) ||
                       ((r_op == 4'd1) && (r_nb != 32'd3));
    assign w_k_last   = (32'(r_k) == (r_nb - 32'd1));
    assign w_push_ok  = !core_in1_full && !core_in2_full;
    // Cross emits three bands, dot emits only the scalar in band 0.
    assign w_last_idx = (r_op == 4'd1) ? 2'd2 : 2'd0;

    assign s_ready        = (r_state == S_LOAD1) || (r_state == S_LOAD2);
    assign core_in1_wr_en = (r_state == S_PUSH) && w_push_ok;
    assign core_in2_wr_en = (r_state == S_PUSH) && w_push_ok;
    assign core_start     = (r_state == S_KICK);
    assign core_out_rd_en = (r_state == S_POP) && !core_out_empty;
    assign core_in1_data  = r_vec1;
    assign core_in2_data  = r_vec2;
    assign core_op_code   = r_op;
    assign core_num_bands = r_nb;
    assign busy           = (r_state != S_IDLE) && (r_state != S_FIN);
    assign done           = (r_state == S_FIN);
    assign err_code       = r_err;
    assign m_valid        = (r_state == S_EMIT);
    assign m_last         = m_valid && (r_j == w_last_idx);

    always_comb begin
        m_data = '0;
        if (m_valid) begin
            case (r_j)
                2'd1:    m_data = r_res[COMPONENT_WIDTH +: COMPONENT_WIDTH];
                2'd2:    m_data = r_res[2*COMPONENT_WIDTH +: COMPONENT_WIDTH];
                default: m_data = r_res[0 +: COMPONENT_WIDTH];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_nb    <= '0;
            r_pix   <= '0;
            r_k     <= '0;
            r_j     <= '0;
            r_to    <= '0;
            r_err   <= '0;
            r_vec1  <= '0;
            r_vec2  <= '0;
            r_res   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_op    <= cfg_op_code;
                        r_nb    <= cfg_num_bands;
                        r_pix   <= cfg_num_pixels;
                        r_err   <= 4'd0;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_bad_cfg) begin
                        r_err   <= 4'd6;
                        r_state <= S_FIN;
                    end else if (r_pix == 16'd0) begin
                        r_state <= S_FIN;
                    end else begin
                        r_vec1  <= '0;
                        r_k     <= '0;
                        r_state <= S_LOAD1;
                    end
                end
                S_LOAD1: begin
                    if (s_valid) begin
                        r_vec1[r_k*COMPONENT_WIDTH +: COMPONENT_WIDTH] <= s_data;
                        if (w_k_last) begin
                            r_vec2  <= '0;
                            r_k     <= '0;
                            r_state <= S_LOAD2;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                S_LOAD2: begin
                    if (s_valid) begin
                        r_vec2[r_k*COMPONENT_WIDTH +: COMPONENT_WIDTH] <= s_data;
                        if (w_k_last) begin
                            r_k     <= '0;
                            r_state <= S_PUSH;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                S_PUSH: begin
                    if (w_push_ok) r_state <= S_KICK;
                end
                S_KICK: begin
                    r_to    <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_error_code != 4'd0) begin
                        r_err   <= core_error_code;
                        r_state <= S_FIN;
                    end else if (core_pixel_done) begin
                        r_state <= S_POP;
                    end else if (r_to == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_err   <= 4'd5;
                        r_state <= S_FIN;
                    end else begin
                        r_to <= r_to + 1'b1;
                    end
                end
                S_POP: begin
                    if (!core_out_empty) r_state <= S_CAPT;
                end
                // Registered FIFO read: data appears the cycle after rd_en.
                S_CAPT: begin
                    r_res   <= core_out_data;
                    r_j     <= '0;
                    r_state <= S_EMIT;
                end
                S_EMIT: begin
                    if (m_ready) begin
                        if (r_j == w_last_idx) begin
                            r_pix <= r_pix - 16'd1;
                            if (r_pix != 16'd1) begin
                                r_vec1  <= '0;
                                r_k     <= '0;
                                r_state <= S_LOAD1;
                            end else begin
                                r_state <= S_FIN;
                            end
                        end else begin
                            r_j <= r_j + 2'd1;
                        end
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hsi_core_driver.sv
// Directed bench for hsi_core_driver: table of jobs against a small behavioural core
// model, plus hand-written PUSH backpressure and mid-job reset sequences.
module tb_hsi_core_driver;

    localparam int CW = 16;
    localparam int CM = 200;
    localparam int VW = CW * CM;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          go = 1'b0;
    logic [3:0]    cfg_op_code = '0;
    logic [31:0]   cfg_num_bands = '0;
    logic [15:0]   cfg_num_pixels = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [CW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [CW-1:0] m_data;
    logic          m_last;
    logic          core_in1_wr_en, core_in2_wr_en;
    logic [VW-1:0] core_in1_data, core_in2_data;
    logic          core_in1_full = 1'b0, core_in2_full = 1'b0;
    logic          core_out_rd_en;
    logic          core_out_empty;
    logic [VW-1:0] core_out_data;
    logic [3:0]    core_op_code;
    logic [31:0]   core_num_bands;
    logic          core_start;
    logic          core_pixel_done;
    logic [3:0]    core_error_code;
    logic          busy, done;
    logic [3:0]    err_code;

    hsi_core_driver #(.COMPONENT_WIDTH(CW), .COMPONENTS_MAX(CM), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .go(go),
        .cfg_op_code(cfg_op_code), .cfg_num_bands(cfg_num_bands), .cfg_num_pixels(cfg_num_pixels),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .core_in1_wr_en(core_in1_wr_en), .core_in1_data(core_in1_data), .core_in1_full(core_in1_full),
        .core_in2_wr_en(core_in2_wr_en), .core_in2_data(core_in2_data), .core_in2_full(core_in2_full),
        .core_out_rd_en(core_out_rd_en), .core_out_empty(core_out_empty), .core_out_data(core_out_data),
        .core_op_code(core_op_code), .core_num_bands(core_num_bands), .core_start(core_start),
        .core_pixel_done(core_pixel_done), .core_error_code(core_error_code),
        .busy(busy), .done(done), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]             op;
        logic [31:0]            nb;
        logic [15:0]            npix;
        int                     mode;   // core model: 0 normal, 1 error code 2, 2 silent
        bit                     tog;    // toggle m_ready during EMIT
        logic [1:0][3:0][15:0]  a;
        logic [1:0][3:0][15:0]  b;
        int                     beats;
        int                     ncnt;
        logic [3:0][15:0]       em;
        logic [3:0]             el;
        logic [3:0]             eerr;
        int                     ewr;
        int                     est;
    } vec_t;

    vec_t tv[11];
    vec_t cur;

    int nchk = 0, nerr = 0;
    int cyc = 0;
    int wr1_cnt, wr2_cnt, st_cnt, acc_cnt, done_cnt, done_cyc, st_cyc;
    logic [15:0] srcq[$];
    logic [15:0] ms[$];
    logic        ml[$];
    int          model_mode = 0;
    bit          tog_en = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] nb, input logic [15:0] npix,
                                input int mode, input bit tog,
                                input logic [63:0] a0, input logic [63:0] a1,
                                input logic [63:0] b0, input logic [63:0] b1,
                                input int beats, input int ncnt, input logic [63:0] em,
                                input logic [3:0] el, input logic [3:0] eerr,
                                input int ewr, input int est);
        vec_t v;
        v.op = op; v.nb = nb; v.npix = npix; v.mode = mode; v.tog = tog;
        v.a[0] = a0; v.a[1] = a1; v.b[0] = b0; v.b[1] = b1;
        v.beats = beats; v.ncnt = ncnt; v.em = em; v.el = el; v.eerr = eerr;
        v.ewr = ewr; v.est = est;
        return v;
    endfunction

    function automatic logic [VW-1:0] pack(input logic [3:0][15:0] v, input logic [31:0] nb);
        logic [VW-1:0] r;
        r = '0;
        for (int k = 0; k < 4; k++)
            if (32'(k) < nb) r[k*16 +: 16] = v[k];
        return r;
    endfunction

    // Behavioural core arithmetic (cross / wrapping 16-bit dot).
    function automatic logic [VW-1:0] calc(input logic [VW-1:0] x, input logic [VW-1:0] y,
                                           input logic [3:0] op, input logic [31:0] nb);
        logic [VW-1:0] r;
        logic [15:0]   acc;
        r = '0;
        if (op == 4'd1) begin
            r[0 +: 16]  = 16'(x[16 +: 16] * y[32 +: 16] - x[32 +: 16] * y[16 +: 16]);
            r[16 +: 16] = 16'(x[32 +: 16] * y[0 +: 16]  - x[0 +: 16]  * y[32 +: 16]);
            r[32 +: 16] = 16'(x[0 +: 16]  * y[16 +: 16] - x[16 +: 16] * y[0 +: 16]);
        end else begin
            acc = '0;
            for (int k = 0; k < CM; k++)
                if (32'(k) < nb) acc = 16'(acc + x[k*16 +: 16] * y[k*16 +: 16]);
            r[0 +: 16] = acc;
        end
        return r;
    endfunction

    // Core model: pixel_done / error three cycles after start, registered output FIFO read.
    logic [VW-1:0] mv1, mv2, mres;
    int            cnt_dn;
    initial begin
        core_out_empty  = 1'b1;
        core_out_data   = '0;
        core_pixel_done = 1'b0;
        core_error_code = '0;
        cnt_dn = 0; mv1 = '0; mv2 = '0; mres = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                core_out_empty  <= 1'b1;
                core_pixel_done <= 1'b0;
                core_error_code <= '0;
                cnt_dn = 0;
            end else begin
                core_pixel_done <= 1'b0;
                core_error_code <= '0;
                if (core_in1_wr_en) mv1 = core_in1_data;
                if (core_in2_wr_en) mv2 = core_in2_data;
                if (cnt_dn == 1) begin
                    if (model_mode == 0) begin
                        mres = calc(mv1, mv2, core_op_code, core_num_bands);
                        core_pixel_done <= 1'b1;
                        core_out_empty  <= 1'b0;
                    end else if (model_mode == 1) begin
                        core_error_code <= 4'd2;
                    end
                end
                if (cnt_dn > 0) cnt_dn--;
                if (core_start) cnt_dn = 3;
                if (core_out_rd_en) begin
                    core_out_data  <= mres;
                    core_out_empty <= 1'b1;
                end
            end
        end
    end

    // Source and sink drivers change on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            s_valid = (srcq.size() != 0);
            s_data  = (srcq.size() != 0) ? srcq[0] : 16'd0;
            m_ready = tog_en ? ~m_ready : 1'b1;
        end
    end

    // Monitor: samples handshakes at the rising edge, before state updates.
    logic        stall_prev = 1'b0;
    logic [15:0] hd;
    logic        hl;
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (s_valid && s_ready) begin
                void'(srcq.pop_front());
                acc_cnt++;
            end
            if (core_in1_wr_en) begin
                chk("in1_data", longint'(core_in1_data == pack(cur.a[(wr1_cnt > 0) ? 1 : 0], cur.nb)), 1);
                wr1_cnt++;
            end
            if (core_in2_wr_en) begin
                chk("in2_data", longint'(core_in2_data == pack(cur.b[(wr2_cnt > 0) ? 1 : 0], cur.nb)), 1);
                wr2_cnt++;
            end
            if (core_start) begin
                st_cnt++;
                st_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (stall_prev && m_valid)
                chk("m_hold", longint'({m_data, m_last} == {hd, hl}), 1);
            if (m_valid && m_ready) begin
                ms.push_back(m_data);
                ml.push_back(m_last);
            end
            stall_prev = m_valid && !m_ready;
            hd = m_data;
            hl = m_last;
        end
    end

    task automatic start_job(input int i);
        int np;
        @(negedge clk);
        cur = tv[i];
        model_mode = tv[i].mode;
        tog_en = tv[i].tog;
        wr1_cnt = 0; wr2_cnt = 0; st_cnt = 0; acc_cnt = 0; done_cnt = 0;
        done_cyc = 0; st_cyc = 0;
        ms.delete(); ml.delete();
        np = (tv[i].beats == 0) ? 0 : tv[i].beats / (2 * int'(tv[i].nb));
        for (int p = 0; p < np; p++) begin
            for (int k = 0; k < int'(tv[i].nb); k++) srcq.push_back(tv[i].a[p][k]);
            for (int k = 0; k < int'(tv[i].nb); k++) srcq.push_back(tv[i].b[p][k]);
        end
        cfg_op_code = tv[i].op;
        cfg_num_bands = tv[i].nb;
        cfg_num_pixels = tv[i].npix;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        cfg_op_code = 4'hf;
        cfg_num_bands = '1;
    endtask

    task automatic finish_job(input int i);
        int t;
        t = 0;
        while (done_cnt == 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", done_cnt, 1);
        repeat (2) @(negedge clk);
        tog_en = 1'b0;
        chk("done_pulses", done_cnt, 1);
        chk("err_code", err_code, tv[i].eerr);
        chk("busy_after", busy, 0);
        chk("wr1_cnt", wr1_cnt, tv[i].ewr);
        chk("wr2_cnt", wr2_cnt, tv[i].ewr);
        chk("start_cnt", st_cnt, tv[i].est);
        chk("beats_taken", acc_cnt, tv[i].beats);
        chk("m_count", ms.size(), tv[i].ncnt);
        for (int k = 0; k < tv[i].ncnt && k < ms.size(); k++) begin
            chk("m_data", ms[k], tv[i].em[k]);
            chk("m_last", ml[k], tv[i].el[k]);
        end
        if (tv[i].mode == 2) chk("timeout_len", done_cyc - st_cyc, 65);
        srcq.delete();
    endtask

    initial begin
        // op nb npix mode tog | a0 a1 | b0 b1 | beats ncnt em el err wr st
        tv[0] = mk(1, 3, 1, 0, 0, {16'd0, 16'd0, 16'd0, 16'd1}, 64'd0, {16'd0, 16'd0, 16'd1, 16'd0}, 64'd0,
                   6, 3, {16'd0, 16'd1, 16'd0, 16'd0}, 4'b0100, 0, 1, 1);
        tv[1] = mk(2, 4, 2, 0, 0, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd1, 16'd1, 16'd1, 16'd1},
                   {16'd8, 16'd7, 16'd6, 16'd5}, {16'd2, 16'd2, 16'd2, 16'd2},
                   16, 2, {16'd0, 16'd0, 16'd8, 16'd70}, 4'b0011, 0, 2, 2);
        tv[2] = mk(1, 4, 1, 0, 0, 64'd0, 64'd0, 64'd0, 64'd0, 0, 0, 64'd0, 4'b0, 6, 0, 0);
        tv[3] = mk(2, 201, 1, 0, 0, 64'd0, 64'd0, 64'd0, 64'd0, 0, 0, 64'd0, 4'b0, 6, 0, 0);
        tv[4] = mk(2, 0, 1, 0, 0, 64'd0, 64'd0, 64'd0, 64'd0, 0, 0, 64'd0, 4'b0, 6, 0, 0);
        tv[5] = mk(3, 3, 1, 0, 0, 64'd0, 64'd0, 64'd0, 64'd0, 0, 0, 64'd0, 4'b0, 6, 0, 0);
        tv[6] = mk(2, 4, 0, 0, 0, 64'd0, 64'd0, 64'd0, 64'd0, 0, 0, 64'd0, 4'b0, 0, 0, 0);
        tv[7] = mk(2, 2, 1, 1, 0, {16'd0, 16'd0, 16'd2, 16'd1}, 64'd0, {16'd0, 16'd0, 16'd4, 16'd3}, 64'd0,
                   4, 0, 64'd0, 4'b0, 2, 1, 1);
        tv[8] = mk(2, 1, 1, 2, 0, {16'd0, 16'd0, 16'd0, 16'd9}, 64'd0, {16'd0, 16'd0, 16'd0, 16'd9}, 64'd0,
                   2, 0, 64'd0, 4'b0, 5, 1, 1);
        tv[9] = mk(1, 3, 1, 0, 1, {16'd0, 16'd4, 16'd3, 16'd2}, 64'd0, {16'd0, 16'd7, 16'd6, 16'd5}, 64'd0,
                   6, 3, {16'd0, 16'd65533, 16'd6, 16'd65533}, 4'b0100, 0, 1, 1);
        tv[10] = mk(2, 4, 1, 0, 0, {16'd4, 16'd3, 16'd2, 16'd1}, 64'd0, {16'd8, 16'd7, 16'd6, 16'd5}, 64'd0,
                    8, 1, {16'd0, 16'd0, 16'd0, 16'd70}, 4'b0001, 0, 1, 1);
        cur = tv[0];
        wr1_cnt = 0; wr2_cnt = 0; st_cnt = 0; acc_cnt = 0; done_cnt = 0; done_cyc = 0; st_cyc = 0;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_sready", s_ready, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_err", err_code, 0);
        chk("rst_in1_zero", longint'(core_in1_data == '0), 1);
        chk("rst_strobes", {core_in1_wr_en, core_in2_wr_en, core_start, core_out_rd_en, done}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            start_job(i);
            finish_job(i);
        end

        // PUSH must hold while FIFO 1 reports full.
        core_in1_full = 1'b1;
        start_job(0);
        for (int t = 0; t < 200 && srcq.size() != 0; t++) @(negedge clk);
        chk("bp_loaded", srcq.size(), 0);
        repeat (10) @(negedge clk);
        chk("bp_no_wr1", wr1_cnt, 0);
        chk("bp_no_wr2", wr2_cnt, 0);
        chk("bp_busy", busy, 1);
        core_in1_full = 1'b0;
        finish_job(0);

        // Reset during LOAD2, then a clean job.
        start_job(10);
        for (int t = 0; t < 200 && srcq.size() > 2; t++) @(negedge clk);
        chk("mid_in_load2", s_ready, 1);
        rst = 1'b1;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_sready", s_ready, 0);
        chk("mr_in1_zero", longint'(core_in1_data == '0), 1);
        chk("mr_in2_zero", longint'(core_in2_data == '0), 1);
        chk("mr_strobes", {core_in1_wr_en, core_in2_wr_en, core_start, m_valid, done}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        srcq.delete();
        repeat (3) @(negedge clk);
        chk("mr_no_wr", wr1_cnt + st_cnt, 0);
        start_job(10);
        finish_job(10);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
